// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and width limits.
package serial_adder_pkg;

   localparam int unsigned SA_MAX_WIDTH = 32;
   localparam int unsigned ST_W         = 2;

   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
   localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full-adder cell shared by every bit position.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock,
// with the carry registered between bits.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  state_next;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             accept_c;
   logic             last_c;
   logic             s_c;
   logic             c_c;

   fa_bit u_fa (
      .a  (sa[0]),
      .b  (sb[0]),
      .ci (carry),
      .s  (s_c),
      .co (c_c)
   );

   // Next-state: start is only honoured when no operation is in flight.
   always_comb begin
      state_next = state;
      accept_c   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
      last_c     = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
      case (state)
         ST_IDLE: if (bus.start) state_next = ST_RUN;
         ST_RUN:  if (last_c)    state_next = ST_DONE;
         ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Datapath; the result word only updates on the final bit so it never shows partial sums.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa       <= '0;
         sb       <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
      end else begin
         bus.busy <= (state_next == ST_RUN);
         bus.done <= (state_next == ST_DONE);
         if (accept_c) begin
            sa    <= bus.a;
            sb    <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            acc   <= '0;
         end else if (state == ST_RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            acc   <= {s_c, acc[WIDTH-1:1]};
            carry <= c_c;
            cnt   <= cnt + CNT_W'(1);
         end
         if (last_c) begin
            bus.sum  <= {s_c, acc[WIDTH-1:1]};
            bus.cout <= c_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, corner sequences,
// random operands against an arithmetic model, and an exhaustive 4-bit sweep.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) bus8 ();
   serial_adder_if #(.WIDTH(4)) bus4 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] last_sum    = 8'h00;
   logic       last_cout   = 1'b0;
   vec_t       tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      return 9'(a) + 9'(b) + 9'(cin);
   endfunction

   // One 8-bit operation: busy for 8 cycles with held result, then a done pulse.
   // inj>0 re-drives start with FF/FF in that busy cycle; scramble churns inputs while busy.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] esum, input logic ecout, input int inj, input bit scramble);
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) bus8.start = 1'b0;
         if (inj != 0 && i == inj) begin
            bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
         end
         if (inj != 0 && i == inj + 1) bus8.start = 1'b0;
         if (scramble) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
         end
         chk("busy_run", 32'(bus8.busy), 32'd1);
         chk("done_run", 32'(bus8.done), 32'd0);
         chk("sum_held", 32'(bus8.sum), 32'(last_sum));
         chk("cout_held", 32'(bus8.cout), 32'(last_cout));
      end
      bus8.start = 1'b0;
      @(negedge clk);
      chk("done_pulse", 32'(bus8.done), 32'd1);
      chk("busy_done", 32'(bus8.busy), 32'd0);
      chk("sum", 32'(bus8.sum), 32'(esum));
      chk("cout", 32'(bus8.cout), 32'(ecout));
      last_sum  = esum;
      last_cout = ecout;
   endtask

   initial begin
      logic [8:0] r;
      logic [4:0] r4;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;

      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      tbl[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
      tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      rst_n = 1'b0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus8.busy), 32'd0);
      chk("rst_done", 32'(bus8.done), 32'd0);
      chk("rst_sum", 32'(bus8.sum), 32'd0);
      chk("rst_cout", 32'(bus8.cout), 32'd0);
      chk("rst_w4", 32'({bus4.busy, bus4.done, bus4.sum, bus4.cout}), 32'd0);
      rst_n = 1'b1;

      // Directed table
      for (int k = 0; k < 6; k++)
         op8(tbl[k].a, tbl[k].b, tbl[k].cin, tbl[k].sum, tbl[k].cout, 0, 1'b0);

      // start during RUN is ignored
      op8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 3, 1'b0);

      // reset mid-operation aborts without a done
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) bus8.start = 1'b0;
         chk("abort_busy", 32'(bus8.busy), 32'd1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy0", 32'(bus8.busy), 32'd0);
      chk("abort_done0", 32'(bus8.done), 32'd0);
      chk("abort_sum", 32'(bus8.sum), 32'd0);
      chk("abort_cout", 32'(bus8.cout), 32'd0);
      rst_n = 1'b1;
      last_sum = 8'h00; last_cout = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_quiet", 32'({bus8.busy, bus8.done}), 32'd0);
      end
      op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0);

      // start held high: back-to-back operations, done every 9 cycles
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0;
      for (int i = 1; i <= 27; i++) begin
         @(negedge clk);
         chk("b2b_done", 32'(bus8.done), 32'((i % 9) == 0));
         chk("b2b_busy", 32'(bus8.busy), 32'((i % 9) != 0));
         if ((i % 9) == 0) begin
            chk("b2b_sum", 32'(bus8.sum), 32'h03);
            chk("b2b_cout", 32'(bus8.cout), 32'd0);
         end
         if (i == 27) bus8.start = 1'b0;
      end
      last_sum = 8'h03; last_cout = 1'b0;

      // Random operands, inputs churned after acceptance
      for (int k = 0; k < 150; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         r  = model8(ra, rb, rc);
         op8(ra, rb, rc, r[7:0], r[8], 0, 1'b1);
      end

      // WIDTH=4 exhaustive sweep
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               r4 = 5'(ia) + 5'(ib) + 5'(ic);
               @(negedge clk);
               bus4.start = 1'b1; bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.cin = 1'(ic);
               for (int i = 1; i <= 5; i++) begin
                  @(negedge clk);
                  if (i == 1) bus4.start = 1'b0;
                  if (i < 5) chk("w4_busy", 32'({bus4.busy, bus4.done}), 32'b10);
                  else begin
                     chk("w4_done", 32'({bus4.busy, bus4.done}), 32'b01);
                     chk("w4_result", 32'({bus4.cout, bus4.sum}), 32'(r4));
                  end
               end
            end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
